// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave over a word-addressed register memory.
// Independent single-outstanding read and write channels, fixed read latency.
module axi_sram_slave #(
   parameter int MEM_AW = 10,
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [3:0]  wid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int DEPTH = 1 << MEM_AW;
   localparam int LW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rstate_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;

   logic [31:0] mem [DEPTH];

   function automatic logic [31:0] nxt_addr(
      input logic [31:0] a,
      input logic [3:0]  len,
      input logic [2:0]  size,
      input logic [1:0]  burst
   );
      logic [31:0] inc;
      logic [31:0] msk;
      inc = a + (32'd1 << size);
      msk = (({28'd0, len} + 32'd1) << size) - 32'd1;
      case (burst)
         2'd0:    nxt_addr = a;
         2'd2:    nxt_addr = (a & ~msk) | (inc & msk);
         default: nxt_addr = inc;
      endcase
   endfunction

   function automatic logic cfg_err(
      input logic [31:0] a,
      input logic [3:0]  len,
      input logic [2:0]  size,
      input logic [1:0]  burst
   );
      logic [31:0] amsk;
      logic        len_ok;
      amsk   = (32'd1 << size) - 32'd1;
      len_ok = (len == 4'd1) || (len == 4'd3) ||
               (len == 4'd7) || (len == 4'd15);
      cfg_err = (size > 3'd2) || (burst == 2'd3) ||
                ((burst == 2'd2) && (!len_ok || ((a & amsk) != 32'd0)));
   endfunction

   // ---------------- read channel ----------------
   rstate_e     r_state_q, r_state_d;
   logic [3:0]  r_id_q, r_id_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [3:0]  r_len_q, r_len_d;
   logic [2:0]  r_size_q, r_size_d;
   logic [1:0]  r_burst_q, r_burst_d;
   logic        r_err_q, r_err_d;
   logic [3:0]  r_beat_q, r_beat_d;
   logic [LW-1:0] r_lat_q, r_lat_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] r_nxt;
   logic        r_load;
   logic [MEM_AW-1:0] r_idx;

   assign r_nxt = nxt_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_err_q   <= 1'b0;
         r_beat_q  <= '0;
         r_lat_q   <= '0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_err_q   <= r_err_d;
         r_beat_q  <= r_beat_d;
         r_lat_q   <= r_lat_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_err_d   = r_err_q;
      r_beat_d  = r_beat_q;
      r_lat_d   = r_lat_q;
      r_load    = 1'b0;
      r_idx     = r_addr_q[MEM_AW+1:2];
      unique case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               r_id_d    = arid;
               r_addr_d  = araddr;
               r_len_d   = arlen;
               r_size_d  = arsize;
               r_burst_d = arburst;
               r_err_d   = cfg_err(araddr, arlen, arsize, arburst);
               r_beat_d  = '0;
               r_lat_d   = LW'(RD_LAT);
               if (RD_LAT == 0) begin
                  r_state_d = R_DATA;
                  r_load    = 1'b1;
                  r_idx     = araddr[MEM_AW+1:2];
               end else begin
                  r_state_d = R_LAT;
               end
            end
         end
         R_LAT: begin
            r_lat_d = r_lat_q - LW'(1);
            if (r_lat_q == LW'(1)) begin
               r_state_d = R_DATA;
               r_load    = 1'b1;
            end
         end
         R_DATA: begin
            if (rready) begin
               if (r_beat_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_beat_d = r_beat_q + 4'd1;
                  r_addr_d = r_nxt;
                  r_load   = 1'b1;
                  r_idx    = r_nxt[MEM_AW+1:2];
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // Memory read sees pre-write contents for a same-edge write.
      rdata_d = rdata_q;
      if (r_load) rdata_d = r_err_d ? 32'd0 : mem[r_idx];
   end

   always_comb begin
      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_DATA);
      rlast   = rvalid && (r_beat_q == r_len_q);
      rresp   = (rvalid && r_err_q) ? 2'd2 : 2'd0;
      rid     = r_id_q;
      rdata   = rdata_q;
   end

   // ---------------- write channel ----------------
   wstate_e     w_state_q, w_state_d;
   logic [3:0]  w_id_q, w_id_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [3:0]  w_len_q, w_len_d;
   logic [2:0]  w_size_q, w_size_d;
   logic [1:0]  w_burst_q, w_burst_d;
   logic        w_cfg_q, w_cfg_d;
   logic        w_err_q, w_err_d;
   logic [3:0]  w_beat_q, w_beat_d;
   logic        w_we;
   logic        w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_cfg_q   <= 1'b0;
         w_err_q   <= 1'b0;
         w_beat_q  <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_cfg_q   <= w_cfg_d;
         w_err_q   <= w_err_d;
         w_beat_q  <= w_beat_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_size_d  = w_size_q;
      w_burst_d = w_burst_q;
      w_cfg_d   = w_cfg_q;
      w_err_d   = w_err_q;
      w_beat_d  = w_beat_q;
      w_we      = 1'b0;
      w_last    = (w_beat_q == w_len_q);
      unique case (w_state_q)
         W_IDLE: begin
            if (awvalid) begin
               w_id_d    = awid;
               w_addr_d  = awaddr;
               w_len_d   = awlen;
               w_size_d  = awsize;
               w_burst_d = awburst;
               w_cfg_d   = cfg_err(awaddr, awlen, awsize, awburst);
               w_err_d   = 1'b0;
               w_beat_d  = '0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               w_we = !w_cfg_q;
               if ((wid != w_id_q) || (wlast != w_last)) w_err_d = 1'b1;
               // Early wlast terminates the burst as well.
               if (wlast || w_last) begin
                  w_state_d = W_RESP;
               end else begin
                  w_beat_d = w_beat_q + 4'd1;
                  w_addr_d = nxt_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
               end
            end
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      awready = (w_state_q == W_IDLE);
      wready  = (w_state_q == W_DATA);
      bvalid  = (w_state_q == W_RESP);
      bid     = w_id_q;
      bresp   = (bvalid && (w_err_q || w_cfg_q)) ? 2'd2 : 2'd0;
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) mem[w_addr_q[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed AXI traffic with a queue-based scoreboard.
// A forked monitor checks every R and B handshake against expected entries.
module tb_axi_sram_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [3:0]  arlen = '0;
   logic [2:0]  arsize = '0;
   logic [1:0]  arburst = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [3:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [3:0]  wid = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;

   axi_sram_slave #(.MEM_AW(10), .RD_LAT(2)) dut (
      .clk(clk), .reset(reset),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rbeat_t r_q[$];
   bexp_t  b_q[$];
   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      rbeat_t er;
      bexp_t  eb;
      forever begin
         @(negedge clk);
         if (!reset && rvalid && rready) begin
            if (r_q.size() == 0) begin
               chk("r_unexpected", 64'(rvalid), 64'(0));
            end else begin
               er = r_q.pop_front();
               chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(er));
            end
         end
         if (!reset && bvalid && bready) begin
            if (b_q.size() == 0) begin
               chk("b_unexpected", 64'(bvalid), 64'(0));
            end else begin
               eb = b_q.pop_front();
               chk("b_resp", 64'({bid, bresp}), 64'(eb));
            end
         end
      end
   endtask

   task automatic push_r(input logic [3:0] id, input logic [31:0] d,
                         input logic [1:0] resp, input logic last);
      r_q.push_back('{id: id, data: d, resp: resp, last: last});
   endtask

   task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
      b_q.push_back('{id: id, resp: resp});
   endtask

   // which: 0 = AR, 1 = AW, 2 = W
   task automatic wait_hs(input int which);
      bit ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         ok = (which == 0) ? arready : (which == 1) ? awready : wready;
         @(posedge clk);
         #1;
      end
      chk("handshake", 64'(ok), 64'(1));
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] a,
                        input logic [3:0] len, input logic [2:0] size,
                        input logic [1:0] burst);
      @(posedge clk);
      #1;
      arid = id; araddr = a; arlen = len;
      arsize = size; arburst = burst; arvalid = 1'b1;
      wait_hs(0);
      arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] a,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [31:0] d0,
                           input logic [3:0] strb, input int early);
      @(posedge clk);
      #1;
      awid = id; awaddr = a; awlen = len;
      awsize = size; awburst = burst; awvalid = 1'b1;
      wait_hs(1);
      awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         wid = id;
         wdata = d0 + 32'(i);
         wstrb = strb;
         wlast = (i == int'(len)) || (i == early);
         wvalid = 1'b1;
         wait_hs(2);
         if (wlast) break;
      end
      wvalid = 1'b0;
      wlast = 1'b0;
   endtask

   task automatic wait_r();
      int k = 0;
      while (r_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("r_drain", 64'(r_q.size()), 64'(0));
   endtask

   task automatic wait_b();
      int k = 0;
      while (b_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("b_drain", 64'(b_q.size()), 64'(0));
   endtask

   initial begin
      int cnt;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk("reset_outputs",
          64'({arready, awready, rvalid, wready, bvalid, rid, rdata,
               rresp, rlast, bid, bresp}),
          64'({2'b11, 48'd0}));
      reset = 1'b0;

      // preload word 4, then single-beat read with latency check
      push_b(4'h3, 2'd0);
      do_write(4'h3, 32'h10, 4'd0, 3'd2, 2'd1, 32'h11223344, 4'hF, -1);
      wait_b();
      push_r(4'h2, 32'h11223344, 2'd0, 1'b1);
      do_ar(4'h2, 32'h10, 4'd0, 3'd2, 2'd1);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) chk("arready_low", 64'(arready), 64'(0));
         if (rvalid) break;
      end
      chk("rd_latency", 64'(cnt), 64'(3));
      wait_r();

      // INCR write burst and readback
      push_b(4'h5, 2'd0);
      do_write(4'h5, 32'h20, 4'd3, 3'd2, 2'd1, 32'hA0, 4'hF, -1);
      wait_b();
      for (int i = 0; i < 4; i++)
         push_r(4'h1, 32'hA0 + 32'(i), 2'd0, i == 3);
      do_ar(4'h1, 32'h20, 4'd3, 3'd2, 2'd1);
      wait_r();

      // WRAP read across a 16-byte window
      push_b(4'h6, 2'd0);
      do_write(4'h6, 32'h30, 4'd3, 3'd2, 2'd1, 32'hB0, 4'hF, -1);
      wait_b();
      push_r(4'h3, 32'hB2, 2'd0, 1'b0);
      push_r(4'h3, 32'hB3, 2'd0, 1'b0);
      push_r(4'h3, 32'hB0, 2'd0, 1'b0);
      push_r(4'h3, 32'hB1, 2'd0, 1'b1);
      do_ar(4'h3, 32'h38, 4'd3, 3'd2, 2'd2);
      wait_r();

      // rready stall on beat 1
      for (int i = 0; i < 4; i++)
         push_r(4'h8, 32'hA0 + 32'(i), 2'd0, i == 3);
      do_ar(4'h8, 32'h20, 4'd3, 3'd2, 2'd1);
      for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
      @(posedge clk);
      #1;
      rready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_hold", 64'({rvalid, rid, rdata, rresp, rlast}),
             64'({1'b1, 4'h8, 32'hA1, 2'd0, 1'b0}));
      end
      @(posedge clk);
      #1;
      rready = 1'b1;
      wait_r();

      // partial strobes, early wlast, bad burst type
      push_b(4'h2, 2'd0);
      do_write(4'h2, 32'h40, 4'd0, 3'd2, 2'd1, 32'hFFFFFFFF, 4'hF, -1);
      wait_b();
      push_b(4'h2, 2'd0);
      do_write(4'h2, 32'h40, 4'd0, 3'd2, 2'd1, 32'hDEADBEEF, 4'h3, -1);
      wait_b();
      push_r(4'h2, 32'hFFFFBEEF, 2'd0, 1'b1);
      do_ar(4'h2, 32'h40, 4'd0, 3'd2, 2'd1);
      wait_r();
      push_b(4'h4, 2'd2);
      do_write(4'h4, 32'h50, 4'd3, 3'd2, 2'd1, 32'hC0, 4'hF, 1);
      wait_b();
      push_b(4'h1, 2'd2);
      do_write(4'h1, 32'h20, 4'd0, 3'd2, 2'd3, 32'h55, 4'hF, -1);
      wait_b();
      push_r(4'h1, 32'hA0, 2'd0, 1'b1);
      do_ar(4'h1, 32'h20, 4'd0, 3'd2, 2'd1);
      wait_r();

      // read errors: oversize, bad wrap length, unaligned wrap
      push_r(4'h4, 32'h0, 2'd2, 1'b0);
      push_r(4'h4, 32'h0, 2'd2, 1'b1);
      do_ar(4'h4, 32'h20, 4'd1, 3'd3, 2'd1);
      wait_r();
      for (int i = 0; i < 3; i++) push_r(4'h6, 32'h0, 2'd2, i == 2);
      do_ar(4'h6, 32'h30, 4'd2, 3'd2, 2'd2);
      wait_r();
      push_r(4'h7, 32'h0, 2'd2, 1'b0);
      push_r(4'h7, 32'h0, 2'd2, 1'b1);
      do_ar(4'h7, 32'h32, 4'd1, 3'd2, 2'd2);
      wait_r();

      // reset during beat 2 of a 4-beat read
      for (int i = 0; i < 3; i++) push_r(4'h9, 32'hA0 + 32'(i), 2'd0, 1'b0);
      do_ar(4'h9, 32'h20, 4'd3, 3'd2, 2'd1);
      cnt = 0;
      for (int k = 0; k < 50 && cnt < 3; k++) begin
         @(negedge clk);
         if (rvalid) cnt++;
      end
      #2;
      reset = 1'b1;
      #1;
      chk("reset_abort", 64'({rvalid, arready, rlast, awready, wready, bvalid}),
          64'(6'b010100));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_r();
      push_r(4'h7, 32'h11223344, 2'd0, 1'b1);
      do_ar(4'h7, 32'h10, 4'd0, 3'd2, 2'd1);
      wait_r();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
